microwave_ctrl: RTL and testbench
=================================

MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 Parameter BEEP_CYCLES, default 8: number of clock cycles the beep output stays high in DONE; legal range 1..255.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 clearn  input  1  reset, asynchronous, active-high.
REQ-004 key_valid  input  1  one-cycle strobe; a keypad digit is present on key_digit.
REQ-005 key_digit  input  4  keypad digit, BCD.
REQ-006 start  input  1  start/resume request, level-sampled each cycle.
REQ-007 stop  input  1  stop/cancel request, level-sampled each cycle.
REQ-008 door_closed  input  1  1 = door closed.
REQ-009 timer_zero  input  1  from the min/sec timer; 1 = all digits are 0.
REQ-010 timer_data  output  4  digit presented to the timer's data input.
REQ-011 timer_loadn  output  1  timer synchronous load, active-low.
REQ-012 timer_en  output  1  timer count enable, active-high.
REQ-013 timer_clear  output  1  timer clear request, active-high one-cycle pulse.
REQ-014 mag_on  output  1  magnetron drive.
REQ-015 done  output  1  cook cycle complete.
REQ-016 beep  output  1  audible alarm (see Configuration).
REQ-017 state  output  3  current state encoding, for debug.

Function
REQ-018 The FSM SHALL have the states IDLE=0, SET=1, COOK=2, PAUSE=3 and DONE=4; encodings 5..7 SHALL return to IDLE on the next edge.
REQ-019 A key SHALL be accepted only when key_valid=1, key_digit<=9 and the state is IDLE or SET; an accepted key is ignored in every other state, and digits 10..15 SHALL be ignored.
REQ-020 An accepted key SHALL register timer_data=key_digit and drive timer_loadn=0 for exactly one cycle, starting the cycle after acceptance; the timer shifts the digit in (ones->tens->minutes).
REQ-021 Outside a load pulse, timer_loadn SHALL be 1 and timer_data SHALL hold its last value.
REQ-022 IDLE: an accepted key -> SET; stop -> timer_clear pulse, stay in IDLE.
REQ-023 SET: priority is stop > start > key; stop -> timer_clear pulse and IDLE; start with door_closed=1 and timer_zero=0 -> COOK; start with the door open or timer_zero=1 SHALL be ignored.
REQ-024 COOK: timer_en=1 and mag_on=1, decoded from the registered state, so both assert the first cycle in COOK.
REQ-025 COOK: priority is timer_zero > door open > stop; timer_zero -> DONE; door_closed=0 or stop=1 -> PAUSE.
REQ-026 PAUSE: timer_en=0 and mag_on=0; stop -> timer_clear pulse and IDLE; start with door_closed=1 -> COOK (start is ignored while the door is open).
REQ-027 DONE: done=1, timer_en=0, mag_on=0; start, stop or door_closed=0 -> IDLE, with stop taking priority and issuing a timer_clear pulse.
REQ-028 timer_clear SHALL assert for exactly one cycle, the cycle after the qualifying stop.
REQ-029 A held start, stop or key_valid SHALL be treated as one event per cycle; no extra edge detection is performed.

Reset
REQ-030 While clearn=1: state=IDLE, timer_data=0, timer_loadn=1, timer_en=0, timer_clear=0, mag_on=0, done=0, beep=0, and the beep counter=0, all asynchronously.
REQ-031 Reset asserted in any state, including mid-COOK, SHALL drop mag_on and timer_en immediately without waiting for a clock edge; after release the block starts in IDLE.

Configuration
REQ-032 With macro MICROWAVE_BEEP_EN defined, entering DONE SHALL load an 8-bit counter with BEEP_CYCLES and hold beep=1 while the counter is nonzero, decrementing it each cycle, so beep is high for exactly BEEP_CYCLES cycles.
REQ-033 With MICROWAVE_BEEP_EN defined, leaving DONE SHALL clear the counter and drop beep on the next edge.
REQ-034 Without MICROWAVE_BEEP_EN, beep SHALL be tied to 0 and no counter SHALL be synthesized.

Verification
REQ-035 Load sequence: reset; keys 1, 3, 0 on separate cycles -> three single-cycle timer_loadn=0 pulses with timer_data 1, 3, 0; state=SET; the timer reads 1:30.
REQ-036 Start and completion: after loading 0, 5, start with door_closed=1 -> the next cycle has state=COOK and mag_on=timer_en=1; force timer_zero=1 -> the next cycle has state=DONE, done=1, mag_on=0.
REQ-037 Pause and resume: in COOK, door_closed=0 -> PAUSE, mag_on=0; start with the door still open -> stays in PAUSE; close the door and start -> COOK.
REQ-038 Ignored keys: in SET, apply key_digit=12 -> no loadn pulse; apply key 4 and start in the same cycle with the door closed -> COOK and no loadn pulse.
REQ-039 Reset mid-operation: assert clearn mid-COOK between clock edges -> mag_on=0 before the next edge; after release, state=IDLE.
REQ-040 Beep: with MICROWAVE_BEEP_EN and BEEP_CYCLES=3, reach DONE -> beep=1 for exactly 3 cycles; without the macro, beep stays 0.

Source files
------------

// File: rtl/microwave_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : microwave_ctrl                                             |
// | Description : Microwave oven sequencing FSM. Loads keypad digits into an |
// |               external min/sec down-counter, runs the magnetron while    |
// |               cooking, handles pause/resume on door or stop, and flags   |
// |               completion with an optional beeper.                        |
// | Optional    : define MICROWAVE_BEEP_EN to build the beep counter;        |
// |               otherwise beep is tied low and no counter exists.          |
// | Ports       : clock, clearn (async active-high reset)                    |
// |               key_valid/key_digit  keypad strobe and BCD digit           |
// |               start, stop, door_closed, timer_zero  control inputs       |
// |               timer_data/timer_loadn/timer_en/timer_clear  timer drive   |
// |               mag_on, done, beep  oven outputs; state  debug encoding    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module microwave_ctrl #(
  parameter int unsigned BEEP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_en,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       done,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  if (BEEP_CYCLES < 1 || BEEP_CYCLES > 255) begin : g_beep_cycles_check
    $error("BEEP_CYCLES must be in 1..255");
  end

  state_t     r_state;
  logic [3:0] r_timer_data;
  logic       r_timer_loadn;
  logic       r_timer_clear;

  // Digit is a legal BCD value; state gating is applied inside the FSM.
  logic w_key_ok;
  assign w_key_ok = key_valid && (key_digit <= 4'd9);

  always_ff @(posedge clock or posedge clearn) begin
    if (clearn) begin
      r_state       <= ST_IDLE;
      r_timer_data  <= 4'd0;
      r_timer_loadn <= 1'b1;
      r_timer_clear <= 1'b0;
    end else begin
      // Load and clear are single-cycle pulses unless re-armed below.
      r_timer_loadn <= 1'b1;
      r_timer_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (stop) begin
            r_timer_clear <= 1'b1;
          end else if (w_key_ok) begin
            r_timer_data  <= key_digit;
            r_timer_loadn <= 1'b0;
            r_state       <= ST_SET;
          end
        end
        ST_SET: begin
          if (stop) begin
            r_timer_clear <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (start && door_closed && !timer_zero) begin
            r_state <= ST_COOK;
          end else if (w_key_ok) begin
            // A start that could not be honoured does not mask the key.
            r_timer_data  <= key_digit;
            r_timer_loadn <= 1'b0;
          end
        end
        ST_COOK: begin
          if (timer_zero) begin
            r_state <= ST_DONE;
          end else if (!door_closed || stop) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            r_timer_clear <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (start && door_closed) begin
            r_state <= ST_COOK;
          end
        end
        ST_DONE: begin
          if (stop) begin
            r_timer_clear <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (start || !door_closed) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register so the async reset removes
  // magnetron drive immediately and COOK outputs appear on its first cycle.
  assign timer_en    = (r_state == ST_COOK);
  assign mag_on      = (r_state == ST_COOK);
  assign done        = (r_state == ST_DONE);
  assign timer_data  = r_timer_data;
  assign timer_loadn = r_timer_loadn;
  assign timer_clear = r_timer_clear;
  assign state       = r_state;

`ifdef MICROWAVE_BEEP_EN
  localparam logic [7:0] C_BEEP_LOAD = 8'(BEEP_CYCLES);

  logic [7:0] r_beep_cnt;
  logic       w_enter_done;
  logic       w_leave_done;

  assign w_enter_done = (r_state == ST_COOK) && timer_zero;
  assign w_leave_done = (r_state == ST_DONE) && (stop || start || !door_closed);

  always_ff @(posedge clock or posedge clearn) begin
    if (clearn) begin
      r_beep_cnt <= 8'd0;
    end else if (w_enter_done) begin
      r_beep_cnt <= C_BEEP_LOAD;
    end else if (w_leave_done) begin
      r_beep_cnt <= 8'd0;
    end else if ((r_state == ST_DONE) && (r_beep_cnt != 8'd0)) begin
      r_beep_cnt <= r_beep_cnt - 8'd1;
    end
  end

  assign beep = (r_beep_cnt != 8'd0);
`else
  assign beep = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_microwave_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_microwave_ctrl                                          |
// | Description : Scoreboard bench for microwave_ctrl. A driver issues       |
// |               directed then random stimulus, steps a behavioural oven    |
// |               model and queues the expected outputs; a monitor pops one  |
// |               entry after every rising edge and compares. Honors         |
// |               MICROWAVE_BEEP_EN for the beep expectation.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_microwave_ctrl;

  localparam int BEEP = 3;
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic       clock = 1'b0;
  logic       clearn;
  logic       key_valid, start, stop, door_closed, timer_zero;
  logic [3:0] key_digit;
  logic [3:0] timer_data;
  logic       timer_loadn, timer_en, timer_clear, mag_on, done, beep;
  logic [2:0] state;

  microwave_ctrl #(.BEEP_CYCLES(BEEP)) dut (
    .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_data(timer_data), .timer_loadn(timer_loadn), .timer_en(timer_en),
    .timer_clear(timer_clear), .mag_on(mag_on), .done(done), .beep(beep),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] data;
    logic       loadn, en, clr, mag, dn, bp;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Oven model: current mode, last digit sent, pending pulses, beeps left.
  int m_state, m_data, m_loadn, m_clear, m_beep;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_data = 0; m_loadn = 1; m_clear = 0; m_beep = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st    = 3'(m_state);
    e.data  = 4'(m_data);
    e.loadn = 1'(m_loadn);
    e.en    = (m_state == S_COOK);
    e.clr   = 1'(m_clear);
    e.mag   = (m_state == S_COOK);
    e.dn    = (m_state == S_DONE);
`ifdef MICROWAVE_BEEP_EN
    e.bp    = (m_beep > 0);
`else
    e.bp    = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_step(input bit kv, input int dg, input bit st, input bit sp,
                            input bit dr, input bit tz);
    int ns;
    bit take_key;
    bit kok;
    ns = m_state; take_key = 0; m_loadn = 1; m_clear = 0;
    kok = kv && (dg <= 9);
    case (m_state)
      S_IDLE:  if (sp) m_clear = 1; else if (kok) begin take_key = 1; ns = S_SET; end
      S_SET:   if (sp) begin m_clear = 1; ns = S_IDLE; end
               else if (st && dr && !tz) ns = S_COOK;
               else if (kok) take_key = 1;
      S_COOK:  if (tz) ns = S_DONE; else if (!dr || sp) ns = S_PAUSE;
      S_PAUSE: if (sp) begin m_clear = 1; ns = S_IDLE; end
               else if (st && dr) ns = S_COOK;
      S_DONE:  if (sp) begin m_clear = 1; ns = S_IDLE; end
               else if (st || !dr) ns = S_IDLE;
      default: ns = S_IDLE;
    endcase
    if (take_key) begin m_data = dg; m_loadn = 0; end
    if (ns == S_DONE && m_state != S_DONE) m_beep = BEEP;
    else if (ns == S_DONE && m_beep > 0)   m_beep = m_beep - 1;
    else if (ns != S_DONE)                 m_beep = 0;
    m_state = ns;
  endtask

  // One clock of stimulus: drive on the falling edge, queue the expectation.
  task automatic cyc(input bit kv, input int dg, input bit st, input bit sp,
                     input bit dr, input bit tz);
    @(negedge clock);
    clearn = 1'b0;
    key_valid = kv; key_digit = 4'(dg); start = st; stop = sp;
    door_closed = dr; timer_zero = tz;
    model_step(kv, dg, st, sp, dr, tz);
    q.push_back(model_out());
  endtask

  // Reset between edges: magnetron must drop before any clock edge.
  task automatic async_reset();
    @(negedge clock);
    #2;
    clearn = 1'b1;
    #1;
    chk("async_mag_on", mag_on, 0);
    chk("async_timer_en", timer_en, 0);
    chk("async_state", state, S_IDLE);
    chk("async_loadn", timer_loadn, 1);
    chk("async_beep", beep, 0);
    model_reset();
    q.push_back(model_out());
  endtask

  // Monitor: every edge presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", state, e.st);
        chk("timer_data", timer_data, e.data);
        chk("timer_loadn", timer_loadn, e.loadn);
        chk("timer_en", timer_en, e.en);
        chk("timer_clear", timer_clear, e.clr);
        chk("mag_on", mag_on, e.mag);
        chk("done", done, e.dn);
        chk("beep", beep, e.bp);
      end
    end
  end

  initial begin
    bit kv, st, sp, dr, tz;
    int dg;
    clearn = 1'b1; key_valid = 0; key_digit = 0; start = 0; stop = 0;
    door_closed = 1; timer_zero = 0;
    model_reset();
    #1;
    chk("reset_state", state, S_IDLE);
    chk("reset_loadn", timer_loadn, 1);
    chk("reset_data", timer_data, 0);
    chk("reset_mag_on", mag_on, 0);

    // Load 1:30, illegal digit, key+start together, pause/resume, finish.
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 3, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 12, 0, 0, 1, 0);
    cyc(1, 4, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (5) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    // Load 0:05, cook, then reset in the middle of cooking.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 5, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    async_reset();

    for (int i = 0; i < 4000; i++) begin
      if (m_state == S_COOK && ($urandom % 12) == 0) begin
        async_reset();
      end else begin
        kv = ($urandom % 100) < 30;
        dg = int'($urandom % 16);
        st = ($urandom % 100) < 20;
        sp = ($urandom % 100) < 6;
        dr = ($urandom % 100) < 85;
        tz = ($urandom % 100) < 12;
        // Key-versus-stop ordering in IDLE is left open; avoid the overlap.
        if (m_state == S_IDLE && sp) kv = 0;
        cyc(kv, dg, st, sp, dr, tz);
      end
    end

    repeat (3) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
